// File: rtl/fe_common_pkg.sv
// Field-element constants and limbwise helpers shared by the curve25519 point blocks.
// An element is 10 signed 32-bit limbs, limb 0 in the low bits.
package fe_common;
  localparam int LIMB_W = 32;
  localparam int NLIMB  = 10;
  localparam int FE_W   = LIMB_W * NLIMB;

  // 2*d in radix 2^25.5, limb 9 first in the concatenation
  localparam logic [FE_W-1:0] D2 = {
    32'(9444199),   32'(29715968),  32'(-6495438),  32'(-12551817), 32'(15978800),
    32'(229458),    32'(13898782),  32'(-30745221), 32'(-5839606),  32'(-21827239)
  };

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL_REQ, MUL_WAIT, FIN} cached_state_t;

  function automatic logic [FE_W-1:0] fe_add(input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
    logic [FE_W-1:0] r;
    for (int i = 0; i < NLIMB; i++)
      r[i*LIMB_W +: LIMB_W] = a[i*LIMB_W +: LIMB_W] + b[i*LIMB_W +: LIMB_W];
    return r;
  endfunction

  function automatic logic [FE_W-1:0] fe_sub(input logic [FE_W-1:0] a, input logic [FE_W-1:0] b);
    logic [FE_W-1:0] r;
    for (int i = 0; i < NLIMB; i++)
      r[i*LIMB_W +: LIMB_W] = a[i*LIMB_W +: LIMB_W] - b[i*LIMB_W +: LIMB_W];
    return r;
  endfunction
endpackage

// File: rtl/ge_p3_to_cached.sv
// Converts an extended point (X,Y,Z,T) to cached form (Y+X, Y-X, Z, T*2d)
// using shared add/sub/mul resources driven through ports.
module ge_p3_to_cached
  import fe_common::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [FE_W-1:0] p_x,
  input  logic [FE_W-1:0] p_y,
  input  logic [FE_W-1:0] p_z,
  input  logic [FE_W-1:0] p_t,
  output logic [FE_W-1:0] c_yplusx,
  output logic [FE_W-1:0] c_yminusx,
  output logic [FE_W-1:0] c_z,
  output logic [FE_W-1:0] c_t2d,
  output logic            done,
  output logic [FE_W-1:0] mul_op_a,
  output logic [FE_W-1:0] mul_op_b,
  output logic            mul_valid,
  input  logic [FE_W-1:0] mul_res,
  input  logic            mul_done,
  output logic [FE_W-1:0] add_op_a,
  output logic [FE_W-1:0] add_op_b,
  input  logic [FE_W-1:0] add_res,
  output logic [FE_W-1:0] sub_op_a,
  output logic [FE_W-1:0] sub_op_b,
  input  logic [FE_W-1:0] sub_res
);
  cached_state_t   state;
  logic [FE_W-1:0] x_q, y_q, z_q, t_q;

  // Operands are zero outside their owning state so shared resources see idle inputs.
  assign add_op_a = (state == ADDSUB) ? y_q : '0;
  assign add_op_b = (state == ADDSUB) ? x_q : '0;
  assign sub_op_a = (state == ADDSUB) ? y_q : '0;
  assign sub_op_b = (state == ADDSUB) ? x_q : '0;
  assign mul_op_a = (state == MUL_REQ || state == MUL_WAIT) ? t_q : '0;
  assign mul_op_b = (state == MUL_REQ || state == MUL_WAIT) ? D2  : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      mul_valid <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      t_q       <= '0;
      c_yplusx  <= '0;
      c_yminusx <= '0;
      c_z       <= '0;
      c_t2d     <= '0;
    end else begin
      done      <= 1'b0;
      mul_valid <= 1'b0;
      unique case (state)
        IDLE: if (valid) begin
          x_q   <= p_x;
          y_q   <= p_y;
          z_q   <= p_z;
          t_q   <= p_t;
          state <= ADDSUB;
        end
        ADDSUB: begin
          c_yplusx  <= add_res;
          c_yminusx <= sub_res;
          c_z       <= z_q;
          mul_valid <= 1'b1;
          state     <= MUL_REQ;
        end
        MUL_REQ: state <= MUL_WAIT;
        MUL_WAIT: if (mul_done) begin
          c_t2d <= mul_res;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
